// File: rtl/pool_result_writer.sv
// Captures pooled result vectors on out_pipe_en, buffers them in a small FIFO and
// writes them to consecutive output addresses. Define POOL_WR_RELU_EN to clamp negative lanes to 0.

module pool_wr_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
`ifdef POOL_WR_RELU_EN
  assign dout = din[DATA_W-1] ? '0 : din;
`else
  assign dout = din;
`endif
endmodule

module pool_result_writer #(
  parameter int POOL_UNITS = 32,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [7:0]                   result_cnt,
  input  logic                         out_pipe_en,
  input  logic [POOL_UNITS*DATA_W-1:0] pool_data,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [POOL_UNITS*DATA_W-1:0] mem_data,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf_err
);
  localparam int VEC_W = POOL_UNITS * DATA_W;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [VEC_W-1:0]  push_data;
  logic [VEC_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        res_q, cap_cnt, push_cnt, wr_cnt;
  logic              full, empty, pop, push, drop, strobe_run, start_ok, fifo_last;

  for (genvar g = 0; g < POOL_UNITS; g++) begin : g_lane
    pool_wr_lane #(.DATA_W(DATA_W)) u_lane (
      .din  (pool_data[g*DATA_W +: DATA_W]),
      .dout (push_data[g*DATA_W +: DATA_W])
    );
  end

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop        = !empty && mem_ready;
  assign strobe_run = (state == S_RUN) && out_pipe_en;
  // A full FIFO still takes the vector when the head leaves in the same cycle.
  assign push       = strobe_run && (!full || pop);
  assign drop       = strobe_run && full && !pop;
  assign start_ok   = (state == S_IDLE) && start;
  // FIFO is empty after this cycle's pop, so DONE follows the last write directly.
  assign fifo_last  = empty || ((cnt_q == (PW+1)'(1)) && pop);

  assign mem_valid = !empty;
  assign mem_data  = fifo_q[rd_ptr];
  assign mem_addr  = base_q + ADDR_W'(wr_cnt);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (result_cnt == 8'd0) ? S_DONE : S_RUN;
      S_RUN:   if (strobe_run && (cap_cnt + 8'd1 == res_q)) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_last && (wr_cnt + 8'(pop) == push_cnt)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // cap_cnt counts strobes (drives RUN exit); push_cnt counts stored vectors (drives DONE).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      base_q   <= '0;
      res_q    <= '0;
      cap_cnt  <= '0;
      push_cnt <= '0;
      wr_cnt   <= '0;
      ovf_err  <= 1'b0;
    end else if (start_ok) begin
      base_q   <= base_addr;
      res_q    <= result_cnt;
      cap_cnt  <= '0;
      push_cnt <= '0;
      wr_cnt   <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (strobe_run) cap_cnt  <= cap_cnt + 8'd1;
      if (push)       push_cnt <= push_cnt + 8'd1;
      if (pop)        wr_cnt   <= wr_cnt + 8'd1;
      if (drop)       ovf_err  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pool_result_writer.sv
// Directed bench for pool_result_writer: table of write jobs plus hand sequences
// for overflow, zero count, stray strobes, mid-job reset and optional ReLU.

module tb_pool_result_writer;
  localparam int VW = 32 * 16;

  logic          clk = 0, nrst = 0, start = 0, out_pipe_en = 0, mem_ready = 0;
  logic [9:0]    base_addr = '0;
  logic [7:0]    result_cnt = '0;
  logic [VW-1:0] pool_data = '0;
  logic          mem_valid, busy, done, ovf_err;
  logic [9:0]    mem_addr;
  logic [VW-1:0] mem_data;

  pool_result_writer dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr), .result_cnt(result_cnt),
    .out_pipe_en(out_pipe_en), .pool_data(pool_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int hold = 0, pc = 0;
  logic [3:0] rdy_pat = 4'b1111;

  // monitor state (written only by the monitor)
  logic [9:0]    wq_addr [$];
  logic [VW-1:0] wq_data [$];
  int ncyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, stall_bad = 0, stall_seen = 0;
  logic          stall_p = 0;
  logic [9:0]    p_addr = '0;
  logic [VW-1:0] p_data = '0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (nrst && mem_valid && mem_ready) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_data);
      last_wr_cyc <= ncyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= ncyc;
    end
    if (stall_p && nrst) begin
      stall_seen <= stall_seen + 1;
      if (mem_valid !== 1'b1 || mem_addr !== p_addr || mem_data !== p_data) stall_bad <= stall_bad + 1;
    end
    stall_p <= nrst && mem_valid && !mem_ready;
    p_addr  <= mem_addr;
    p_data  <= mem_data;
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (hold > 0) begin
      mem_ready = 1'b0;
      hold--;
    end else begin
      mem_ready = rdy_pat[pc];
    end
    pc = (pc + 1) % 4;
  endtask

  function automatic logic [VW-1:0] mk(input int v);
    logic [VW-1:0] r;
    for (int k = 0; k < 32; k++) r[k*16 +: 16] = {8'(k), 8'(v)};
    return r;
  endfunction

  logic [VW-1:0] relu_in, relu_exp;

  task automatic run_job(input logic [9:0] base, input logic [7:0] cnt, input logic [3:0] rdy,
                         input int hld, input int exp_n, input logic exp_ovf, input bit relu);
    int wq0, d0, k;
    logic [9:0] ea;
    rdy_pat = rdy;
    hold    = hld;
    wq0 = wq_addr.size();
    d0  = done_cnt;
    start = 1; base_addr = base; result_cnt = cnt;
    step();
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("ovf_clear_on_start", ovf_err, 0);
    for (int i = 0; i < cnt; i++) begin
      out_pipe_en = 1;
      pool_data   = relu ? relu_in : mk(i + 1);
      step();
    end
    out_pipe_en = 0;
    k = 0;
    while (k < 80 && done_cnt == d0) begin
      step();
      k++;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("done_after_last_write", done_cyc, last_wr_cyc + 1);
    chk("ovf_err", ovf_err, exp_ovf);
    step(); step();
    chk("done_one_cycle", done_cnt, d0 + 1);
    chk("busy_low_after", busy, 0);
    chk("write_count", wq_addr.size() - wq0, exp_n);
    if (wq_addr.size() - wq0 == exp_n) begin
      for (int i = 0; i < exp_n; i++) begin
        ea = base + 10'(i);
        chk("wr_addr", wq_addr[wq0 + i], ea);
        chk("wr_data", wq_data[wq0 + i], relu ? relu_exp : mk(i + 1));
      end
    end
  endtask

  typedef struct {
    logic [9:0] base;
    logic [7:0] cnt;
    logic [3:0] rdy;
    logic [9:0] exp_first;
    logic [9:0] exp_last;
  } row_t;
  row_t rows [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wq0, d0;
    bit seen;
    rows[0] = '{base: 10'h010, cnt: 8'd4, rdy: 4'b1111, exp_first: 10'h010, exp_last: 10'h013};
    rows[1] = '{base: 10'h3FE, cnt: 8'd4, rdy: 4'b1111, exp_first: 10'h3FE, exp_last: 10'h001};
    rows[2] = '{base: 10'h020, cnt: 8'd4, rdy: 4'b1001, exp_first: 10'h020, exp_last: 10'h023};
    rows[3] = '{base: 10'h100, cnt: 8'd6, rdy: 4'b1111, exp_first: 10'h100, exp_last: 10'h105};
    relu_in = '0;
    relu_in[15:0]  = 16'hFFF6;
    relu_in[31:16] = 16'h0005;
    relu_exp = relu_in;
`ifdef POOL_WR_RELU_EN
    relu_exp[15:0] = 16'h0000;
`endif

    #12;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf_err, 0);
    nrst = 1;
    step(); step();

    // overflow: memory stalled while 9 strobes arrive, only 4 fit
    run_job(10'h200, 8'd9, 4'b1111, 20, 4, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      wq0 = wq_addr.size();
      run_job(rows[r].base, rows[r].cnt, rows[r].rdy, 0, rows[r].cnt, 1'b0, 1'b0);
      if (wq_addr.size() - wq0 == rows[r].cnt) begin
        chk("row_first_addr", wq_addr[wq0], rows[r].exp_first);
        chk("row_last_addr", wq_addr[wq0 + rows[r].cnt - 1], rows[r].exp_last);
      end
    end
    chk("stall_observed", stall_seen > 0, 1);

    run_job(10'h050, 8'd1, 4'b1111, 0, 1, 1'b0, 1'b1);

    // stray strobes in IDLE produce no write
    rdy_pat = 4'b1111;
    wq0 = wq_addr.size();
    out_pipe_en = 1; pool_data = mk(9);
    step(); step(); step();
    out_pipe_en = 0;
    chk("stray_no_valid", mem_valid, 0);
    step();
    chk("stray_no_write", wq_addr.size() - wq0, 0);

    // zero-count job: done within two cycles, no writes
    d0 = done_cnt;
    start = 1; base_addr = 10'h080; result_cnt = 8'd0;
    step();
    start = 0;
    seen = done;
    step();
    seen = seen | done;
    chk("zero_done_seen", seen, 1);
    step(); step();
    chk("zero_done_once", done_cnt, d0 + 1);
    chk("zero_no_write", wq_addr.size() - wq0, 0);
    chk("zero_busy", busy, 0);

    // reset in the middle of a stalled job
    run_mid_reset();

    chk("stall_stable", stall_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic run_mid_reset();
    int wq0;
    wq0 = wq_addr.size();
    hold = 50;
    start = 1; base_addr = 10'h0C0; result_cnt = 8'd4;
    step();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      out_pipe_en = 1; pool_data = mk(i + 1);
      step();
    end
    out_pipe_en = 0;
    @(negedge clk); #1;
    chk("pre_rst_valid", mem_valid, 1);
    mem_ready = 1;
    nrst = 0;
    #1;
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", mem_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", ovf_err, 0);
    @(negedge clk); #2;
    nrst = 1;
    hold = 0;
    step(); step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", mem_valid, 0);
    chk("rst_no_write", wq_addr.size() - wq0, 0);
  endtask
endmodule
